pulse_transmitter_multi_timer: RTL and testbench

- Parametrised, multi-channel successor of the single countdown timer in the pulse transmitter.
- Each channel is a countdown timer with a double-buffered (shadow) duration/prescaler register, so the next segment is loaded seamlessly at expiry.
- Each channel supports repeat and one-shot modes and raises a sticky underrun flag when it expires with no fresh data.
- Sits between the register/FIFO front-end, which answers request_data, and the pulse output encoders, which consume pulse_out.

---
 rtl/pulse_transmitter_timer_pkg.sv | 24 ++
 rtl/pulse_transmitter_multi_timer_if.sv | 17 +
 rtl/pulse_transmitter_timer_channel.sv | 129 ++++++++++++
 rtl/pulse_transmitter_multi_timer.sv | 51 +++++
 tb/tb_pulse_transmitter_multi_timer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_transmitter_timer_pkg.sv
// Shared types and helpers for the multi-channel pulse transmitter timer.
package pulse_transmitter_timer_pkg;

  // Per-channel controller state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int DEF_TIMER_WIDTH    = 8;
  localparam int DEF_PRESCALER_BITS = 4;

  // One timer segment, {prescaler shift, duration}, at the default widths.
  typedef struct packed {
    logic [DEF_PRESCALER_BITS-1:0] prescaler;
    logic [DEF_TIMER_WIDTH-1:0]    duration;
  } timer_cfg_t;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int ch_index_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_transmitter_multi_timer_if.sv
// Shared shadow-register write bus into the multi-channel timer.
// Handshake: the write strobe has no back-pressure. Every cycle with
// wr_valid=1 is one accepted write of {wr_prescaler, wr_duration} into the
// shadow of channel wr_ch; channel indices outside the block are dropped.
interface pulse_transmitter_multi_timer_if #(
  parameter int CH_W           = 2,
  parameter int TIMER_WIDTH    = 8,
  parameter int PRESCALER_BITS = 4
);
  logic                      wr_valid;
  logic [CH_W-1:0]           wr_ch;
  logic [PRESCALER_BITS-1:0] wr_prescaler;
  logic [TIMER_WIDTH-1:0]    wr_duration;

  modport master (output wr_valid, wr_ch, wr_prescaler, wr_duration);
  modport slave  (input  wr_valid, wr_ch, wr_prescaler, wr_duration);
endinterface

// File: rtl/pulse_transmitter_timer_channel.sv
// One countdown timer channel: double-buffered segment register, prescaled
// countdown, repeat/one-shot expiry handling and a sticky underrun flag.
module pulse_transmitter_timer_channel
  import pulse_transmitter_timer_pkg::*;
#(
  parameter int TIMER_WIDTH    = 8,
  parameter int PRESCALER_BITS = 4
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      en_i,
  input  logic                      oneshot_i,
  input  logic                      wr_en_i,
  input  logic [PRESCALER_BITS-1:0] wr_prescaler_i,
  input  logic [TIMER_WIDTH-1:0]    wr_duration_i,
  input  logic                      underrun_clr_i,
  output logic                      request_data_o,
  output logic                      pulse_out_o,
  output logic                      underrun_o,
  output ch_state_e                 state_o
);

  localparam int PRE_W = (1 << PRESCALER_BITS) - 1;

  typedef struct packed {
    logic [PRESCALER_BITS-1:0] prescaler;
    logic [TIMER_WIDTH-1:0]    duration;
  } cfg_t;

  ch_state_e            state_q, state_d;
  cfg_t                 active_q, active_d;
  cfg_t                 shadow_q, shadow_d;
  logic                 full_q, full_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 underrun_q, underrun_d;
  logic                 ur_set;

  // (1 << p) - 1 without ever forming a value wider than the counter.
  function automatic logic [PRE_W-1:0] pre_reload(input logic [PRESCALER_BITS-1:0] p);
    return ~({PRE_W{1'b1}} << p);
  endfunction

  // Next-state: shadow write, IDLE/RUN control, countdown and expiry handling.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    full_d     = full_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    ur_set     = 1'b0;
    // A same-cycle write lands in the shadow after the old shadow is consumed,
    // so every consume below leaves full_d = wr_en_i.
    if (wr_en_i) begin
      shadow_d = '{prescaler: wr_prescaler_i, duration: wr_duration_i};
      full_d   = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (en_i && full_q) begin
          state_d  = RUN;
          active_d = shadow_q;
          pre_d    = pre_reload(shadow_q.prescaler);
          cnt_d    = shadow_q.duration;
          full_d   = wr_en_i;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (pre_q != '0) begin
          pre_d = pre_q - PRE_W'(1);
        end else if (cnt_q != '0) begin
          pre_d = pre_reload(active_q.prescaler);
          cnt_d = cnt_q - TIMER_WIDTH'(1);
        end else begin
          pulse_d = 1'b1;
          if (oneshot_i) begin
            state_d = IDLE;
          end else if (full_q) begin
            active_d = shadow_q;
            pre_d    = pre_reload(shadow_q.prescaler);
            cnt_d    = shadow_q.duration;
            full_d   = wr_en_i;
          end else begin
            pre_d  = pre_reload(active_q.prescaler);
            cnt_d  = active_q.duration;
            ur_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Setting beats clearing when both happen in one cycle.
    underrun_d = (underrun_q & ~underrun_clr_i) | ur_set;
  end

  // State register with synchronous reset; reset also swallows a pending pulse.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      active_q   <= '0;
      shadow_q   <= '0;
      full_q     <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      full_q     <= full_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      underrun_q <= underrun_d;
    end
  end

  assign request_data_o = en_i & ~full_q;
  assign pulse_out_o    = pulse_q;
  assign underrun_o     = underrun_q;
  assign state_o        = state_q;

endmodule

// File: rtl/pulse_transmitter_multi_timer.sv
// Multi-channel pulse transmitter timer: decodes the shared shadow write bus
// and instantiates one independent timer channel per output.
module pulse_transmitter_multi_timer
  import pulse_transmitter_timer_pkg::*;
#(
  parameter int  NUM_CHANNELS   = 4,
  parameter int  TIMER_WIDTH    = 8,
  parameter int  PRESCALER_BITS = 4,
  localparam int CH_W           = ch_index_width(NUM_CHANNELS)
) (
  input  logic                             clk,
  input  logic                             sys_rst,
  input  logic [NUM_CHANNELS-1:0]          en,
  input  logic [NUM_CHANNELS-1:0]          oneshot,
  pulse_transmitter_multi_timer_if.slave   wr,
  output logic [NUM_CHANNELS-1:0]          request_data,
  output logic [NUM_CHANNELS-1:0]          pulse_out,
  output logic [NUM_CHANNELS-1:0]          busy,
  output logic [NUM_CHANNELS-1:0]          underrun,
  input  logic [NUM_CHANNELS-1:0]          underrun_clr
);

  logic [NUM_CHANNELS-1:0] wr_en;
  ch_state_e               ch_state [NUM_CHANNELS];

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    // An index with no matching channel selects nothing, so it is ignored.
    assign wr_en[i] = wr.wr_valid && (wr.wr_ch == CH_W'(i));

    pulse_transmitter_timer_channel #(
      .TIMER_WIDTH    (TIMER_WIDTH),
      .PRESCALER_BITS (PRESCALER_BITS)
    ) u_ch (
      .clk            (clk),
      .sys_rst        (sys_rst),
      .en_i           (en[i]),
      .oneshot_i      (oneshot[i]),
      .wr_en_i        (wr_en[i]),
      .wr_prescaler_i (wr.wr_prescaler),
      .wr_duration_i  (wr.wr_duration),
      .underrun_clr_i (underrun_clr[i]),
      .request_data_o (request_data[i]),
      .pulse_out_o    (pulse_out[i]),
      .underrun_o     (underrun[i]),
      .state_o        (ch_state[i])
    );

    assign busy[i] = (ch_state[i] == RUN);
  end

endmodule

// File: tb/tb_pulse_transmitter_multi_timer.sv
// Directed bench for the multi-channel pulse transmitter timer.
module tb_pulse_transmitter_multi_timer;
  import pulse_transmitter_timer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [3:0] en, oneshot, underrun_clr;
  logic [3:0] request_data, pulse_out, busy, underrun;
  pulse_transmitter_multi_timer_if #(.CH_W(2), .TIMER_WIDTH(8), .PRESCALER_BITS(4)) wr4 ();

  pulse_transmitter_multi_timer #(.NUM_CHANNELS(4), .TIMER_WIDTH(8), .PRESCALER_BITS(4)) dut4 (
    .clk(clk), .sys_rst(sys_rst), .en(en), .oneshot(oneshot), .wr(wr4.slave),
    .request_data(request_data), .pulse_out(pulse_out), .busy(busy),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  // 3-channel instance, used for the out-of-range channel index
  logic [2:0] en3, oneshot3, underrun_clr3;
  logic [2:0] request_data3, pulse_out3, busy3, underrun3;
  pulse_transmitter_multi_timer_if #(.CH_W(2), .TIMER_WIDTH(8), .PRESCALER_BITS(4)) wr3 ();

  pulse_transmitter_multi_timer #(.NUM_CHANNELS(3), .TIMER_WIDTH(8), .PRESCALER_BITS(4)) dut3 (
    .clk(clk), .sys_rst(sys_rst), .en(en3), .oneshot(oneshot3), .wr(wr3.slave),
    .request_data(request_data3), .pulse_out(pulse_out3), .busy(busy3),
    .underrun(underrun3), .underrun_clr(underrun_clr3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr4(input int ch, input logic [3:0] p, input logic [7:0] d, input logic v);
    wr4.wr_ch        = 2'(ch);
    wr4.wr_prescaler = p;
    wr4.wr_duration  = d;
    wr4.wr_valid     = v;
  endtask

  task automatic do_write(input int ch, input timer_cfg_t c);
    set_wr4(ch, c.prescaler, c.duration, 1'b1);
    tick();
    wr4.wr_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    n_checks++; if (request_data !== 4'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=%b", request_data, 4'b0); end
    n_checks++; if (pulse_out !== 4'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=%b", pulse_out, 4'b0); end
    n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=%b", busy, 4'b0); end
    n_checks++; if (underrun !== 4'b0) begin n_fail++; $display("FAIL reset_underrun got=%b exp=%b", underrun, 4'b0); end
    n_checks++; if ({request_data3, busy3, pulse_out3} !== 9'b0) begin n_fail++; $display("FAIL reset_dut3 got=%b exp=0", {request_data3, busy3, pulse_out3}); end
  endtask

  // ch0 d=3 p=0 repeat: period 4, underrun once the shadow runs dry.
  task automatic test_basic_repeat();
    do_write(0, '{prescaler: 4'd0, duration: 8'd3});
    en[0] = 1'b1;
    n_checks++; if (request_data[0] !== 1'b0) begin n_fail++; $display("FAIL basic_req_full got=%b exp=0", request_data[0]); end
    tick();  // load edge
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy[0]); end
    n_checks++; if (request_data[0] !== 1'b1) begin n_fail++; $display("FAIL basic_req_after_load got=%b exp=1", request_data[0]); end
    for (int j = 1; j <= 12; j++) begin
      tick();
      n_checks++;
      if (pulse_out[0] !== (j % 4 == 0)) begin n_fail++; $display("FAIL basic_pulse j=%0d got=%b exp=%b", j, pulse_out[0], (j % 4 == 0)); end
    end
    n_checks++; if (underrun[0] !== 1'b1) begin n_fail++; $display("FAIL basic_underrun got=%b exp=1", underrun[0]); end
    en[0] = 1'b0;
    tick();
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL basic_stop_busy got=%b exp=0", busy[0]); end
    underrun_clr = 4'b0001;
    tick();
    underrun_clr = 4'b0;
    n_checks++; if (underrun[0] !== 1'b0) begin n_fail++; $display("FAIL basic_clr got=%b exp=0", underrun[0]); end
  endtask

  // ch1 p=2 d=1: period 8, refilled then starved.
  task automatic test_prescaler_refill();
    do_write(1, '{prescaler: 4'd2, duration: 8'd1});
    en[1] = 1'b1;
    tick();  // load edge
    for (int j = 1; j <= 40; j++) begin
      set_wr4(1, 4'd2, 8'd1, (j <= 24) && request_data[1]);
      tick();
      n_checks++;
      if (pulse_out[1] !== (j % 8 == 0)) begin n_fail++; $display("FAIL pre_pulse j=%0d got=%b exp=%b", j, pulse_out[1], (j % 8 == 0)); end
      n_checks++;
      if (underrun[1] !== (j >= 32)) begin n_fail++; $display("FAIL pre_underrun j=%0d got=%b exp=%b", j, underrun[1], (j >= 32)); end
    end
    wr4.wr_valid = 1'b0;
    underrun_clr = 4'b0010;
    tick();
    underrun_clr = 4'b0;
    n_checks++; if (underrun[1] !== 1'b0) begin n_fail++; $display("FAIL pre_clr got=%b exp=0", underrun[1]); end
    en[1] = 1'b0;
    tick();
  endtask

  // ch2 one-shot d=5: single pulse, IDLE, then restart one idle cycle later.
  task automatic test_oneshot();
    oneshot[2] = 1'b1;
    do_write(2, '{prescaler: 4'd0, duration: 8'd5});
    en[2] = 1'b1;
    tick();  // load edge
    for (int j = 1; j <= 14; j++) begin
      set_wr4(2, 4'd0, 8'd5, j == 3);
      tick();
      n_checks++;
      if (pulse_out[2] !== (j == 6 || j == 13)) begin n_fail++; $display("FAIL os_pulse j=%0d got=%b exp=%b", j, pulse_out[2], (j == 6 || j == 13)); end
      n_checks++;
      if (busy[2] !== ((j < 6) || (j >= 7 && j < 13))) begin n_fail++; $display("FAIL os_busy j=%0d got=%b exp=%b", j, busy[2], ((j < 6) || (j >= 7 && j < 13))); end
    end
    wr4.wr_valid = 1'b0;
    en[2] = 1'b0;
    oneshot[2] = 1'b0;
    tick();
  endtask

  // ch0 d=7 with shadow d=4; write d=2 in the expiry cycle.
  task automatic test_write_at_expiry();
    do_write(0, '{prescaler: 4'd0, duration: 8'd7});
    en[0] = 1'b1;
    tick();  // load edge
    for (int j = 1; j <= 16; j++) begin
      set_wr4(0, 4'd0, (j == 8) ? 8'd2 : 8'd4, j == 1 || j == 8);
      tick();
      n_checks++;
      if (pulse_out[0] !== (j == 8 || j == 13 || j == 16)) begin n_fail++; $display("FAIL wexp_pulse j=%0d got=%b exp=%b", j, pulse_out[0], (j == 8 || j == 13 || j == 16)); end
      n_checks++;
      if (request_data[0] !== (j >= 13)) begin n_fail++; $display("FAIL wexp_req j=%0d got=%b exp=%b", j, request_data[0], (j >= 13)); end
      n_checks++;
      if (underrun[0] !== (j >= 16)) begin n_fail++; $display("FAIL wexp_underrun j=%0d got=%b exp=%b", j, underrun[0], (j >= 16)); end
    end
    wr4.wr_valid = 1'b0;
    en[0] = 1'b0;
    tick();
  endtask

  // ch3: drop en on the expiry edge, shadow survives; then reset mid-run.
  task automatic test_enable_drop_and_reset();
    do_write(3, '{prescaler: 4'd0, duration: 8'd3});
    en[3] = 1'b1;
    tick();  // load edge
    for (int j = 1; j <= 4; j++) begin
      set_wr4(3, 4'd0, 8'd1, j == 1);
      if (j == 4) en[3] = 1'b0;
      tick();
      n_checks++;
      if (pulse_out[3] !== 1'b0) begin n_fail++; $display("FAIL drop_pulse j=%0d got=%b exp=0", j, pulse_out[3]); end
    end
    wr4.wr_valid = 1'b0;
    n_checks++; if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL drop_busy got=%b exp=0", busy[3]); end
    en[3] = 1'b1;
    n_checks++; if (request_data[3] !== 1'b0) begin n_fail++; $display("FAIL drop_shadow_kept got=%b exp=0", request_data[3]); end
    tick();  // reload from retained shadow (d=1)
    n_checks++; if (busy[3] !== 1'b1) begin n_fail++; $display("FAIL drop_restart_busy got=%b exp=1", busy[3]); end
    tick();
    n_checks++; if (pulse_out[3] !== 1'b0) begin n_fail++; $display("FAIL drop_restart_p1 got=%b exp=0", pulse_out[3]); end
    tick();
    n_checks++; if (pulse_out[3] !== 1'b1) begin n_fail++; $display("FAIL drop_restart_p2 got=%b exp=1", pulse_out[3]); end
    n_checks++; if (underrun[3] !== 1'b1) begin n_fail++; $display("FAIL drop_underrun got=%b exp=1", underrun[3]); end
    tick();
    sys_rst = 1'b1;  // coincides with the next expiry edge
    tick();
    sys_rst = 1'b0;
    n_checks++; if (pulse_out !== 4'b0) begin n_fail++; $display("FAIL rst_pulse got=%b exp=%b", pulse_out, 4'b0); end
    n_checks++; if (busy !== 4'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=%b", busy, 4'b0); end
    n_checks++; if (underrun !== 4'b0) begin n_fail++; $display("FAIL rst_underrun got=%b exp=%b", underrun, 4'b0); end
    n_checks++; if (request_data !== 4'b1000) begin n_fail++; $display("FAIL rst_req got=%b exp=%b", request_data, 4'b1000); end
    en[3] = 1'b0;
    tick();
  endtask

  // 3-channel block: wr_ch=3 selects no channel.
  task automatic test_bad_channel();
    en3 = 3'b111;
    wr3.wr_ch = 2'd3; wr3.wr_prescaler = 4'd0; wr3.wr_duration = 8'd9; wr3.wr_valid = 1'b1;
    tick();
    wr3.wr_valid = 1'b0;
    n_checks++; if (request_data3 !== 3'b111) begin n_fail++; $display("FAIL badch_req got=%b exp=%b", request_data3, 3'b111); end
    tick();
    n_checks++; if (busy3 !== 3'b000) begin n_fail++; $display("FAIL badch_busy got=%b exp=%b", busy3, 3'b000); end
    wr3.wr_ch = 2'd2; wr3.wr_valid = 1'b1;
    tick();
    wr3.wr_valid = 1'b0;
    n_checks++; if (request_data3 !== 3'b011) begin n_fail++; $display("FAIL goodch_req got=%b exp=%b", request_data3, 3'b011); end
    tick();
    n_checks++; if (busy3 !== 3'b100) begin n_fail++; $display("FAIL goodch_busy got=%b exp=%b", busy3, 3'b100); end
    en3 = 3'b000;
    tick();
  endtask

  // All four channels with periods 2,3,4,5 loaded on the same edge.
  task automatic test_crosstalk();
    timer_cfg_t cfgs [4];
    int per [4];
    logic [3:0] exp_v;
    logic [3:0] got_v;
    cfgs[0] = '{prescaler: 4'd0, duration: 8'd1}; per[0] = 2;
    cfgs[1] = '{prescaler: 4'd0, duration: 8'd2}; per[1] = 3;
    cfgs[2] = '{prescaler: 4'd2, duration: 8'd0}; per[2] = 4;
    cfgs[3] = '{prescaler: 4'd0, duration: 8'd4}; per[3] = 5;
    for (int i = 0; i < 4; i++) do_write(i, cfgs[i]);
    for (int j = 1; j <= 30; j++) begin
      for (int i = 0; i < 4; i++) exp_v[i] = (j % per[i] == 0);
      exp_q.push_back(exp_v);
    end
    en = 4'b1111;
    tick();  // load edge for all channels
    for (int j = 1; j <= 30; j++) begin
      tick();
      got_v = pulse_out;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin n_fail++; $display("FAIL xtalk_pulse j=%0d got=%b exp=%b", j, got_v, exp_v); end
    end
    n_checks++; if (busy !== 4'b1111) begin n_fail++; $display("FAIL xtalk_busy got=%b exp=%b", busy, 4'b1111); end
    en = 4'b0;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    en = '0; oneshot = '0; underrun_clr = '0;
    en3 = '0; oneshot3 = '0; underrun_clr3 = '0;
    wr4.wr_valid = 1'b0; wr4.wr_ch = '0; wr4.wr_prescaler = '0; wr4.wr_duration = '0;
    wr3.wr_valid = 1'b0; wr3.wr_ch = '0; wr3.wr_prescaler = '0; wr3.wr_duration = '0;
    test_reset();
    test_basic_repeat();
    test_prescaler_refill();
    test_oneshot();
    test_write_at_expiry();
    test_enable_drop_and_reset();
    test_bad_channel();
    test_crosstalk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
